// File: rtl/pistorm_pkg.sv
// Shared types and default tuning constants for the PiStorm bus-mastership logic.
package pistorm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOCAL      = 3'd1,
        GRANT_PEND = 3'd2,
        EXTERNAL   = 3'd3,
        RELEASE    = 3'd4
    } arb_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_GRANT_TIMEOUT = 8;
    localparam int DEF_REARB_GAP     = 1;
    localparam int DEF_HOLD_LIMIT    = 4096;

endpackage

// File: rtl/pistorm_sync.sv
// N-stage synchronizer for an active-low asynchronous pin; resets to the idle (1) level.
module pistorm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
        end
    end

    assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus-mastership arbiter: BR/BG/BGACK handshake with external masters,
// local cycle-engine grant, and the bus-control tristate enable.
module m68k_bus_arbiter
    import pistorm_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
    parameter int REARB_GAP     = DEF_REARB_GAP,
    parameter int HOLD_LIMIT    = DEF_HOLD_LIMIT
) (
    input  logic       PI_CLK,
    input  logic       RESET,
    input  logic       C7M_FALL,
    input  logic       M68K_BR_n,
    input  logic       M68K_BGACK_n,
    output logic       M68K_BG_n,
    input  logic       CYC_REQ,
    input  logic       CYC_BUSY,
    output logic       CYC_GRANT,
    output logic       BUS_OWN,
    output logic       EXT_HOLD_OVF,
    input  logic       OVF_CLR,
    output logic [2:0] ARB_STATE
);

    localparam int TMO_W  = $clog2(GRANT_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(REARB_GAP + 1);
    localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

    logic br_s;
    logic bgack_s;

    pistorm_sync #(.STAGES(SYNC_STAGES)) u_sync_br (
        .clk  (PI_CLK),
        .rst  (RESET),
        .din  (M68K_BR_n),
        .dout (br_s)
    );

    pistorm_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .clk  (PI_CLK),
        .rst  (RESET),
        .din  (M68K_BGACK_n),
        .dout (bgack_s)
    );

    arb_state_t        state_reg, state_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              after_ext_reg, after_ext_next;
    logic              from_ext_reg, from_ext_next;
    logic              busy_seen_reg, busy_seen_next;
    logic              ovf_reg, ovf_next;
    logic              bg_n_reg, cyc_grant_reg, bus_own_reg;

    always_comb begin
        state_next     = state_reg;
        tmo_next       = tmo_reg;
        gap_next       = gap_reg;
        hold_next      = hold_reg;
        after_ext_next = after_ext_reg;
        from_ext_next  = from_ext_reg;
        busy_seen_next = busy_seen_reg;
        ovf_next       = ovf_reg & ~OVF_CLR;

        case (state_reg)
            IDLE: begin
                // after_ext lets one local op slip in between back-to-back external tenures
                if (CYC_REQ && (br_s || after_ext_reg) && !CYC_BUSY) begin
                    state_next = LOCAL;
                end else if (!br_s && C7M_FALL && !CYC_BUSY) begin
                    state_next = GRANT_PEND;
                end
            end
            LOCAL: begin
                if (CYC_BUSY) begin
                    busy_seen_next = 1'b1;
                end else if (busy_seen_reg || !CYC_REQ) begin
                    state_next = IDLE;
                end
            end
            GRANT_PEND: begin
                if (C7M_FALL && tmo_reg != TMO_W'(GRANT_TIMEOUT)) begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
                if (!bgack_s) begin
                    state_next = EXTERNAL;
                end else if (br_s || tmo_reg == TMO_W'(GRANT_TIMEOUT)) begin
                    state_next    = RELEASE;
                    from_ext_next = 1'b0;
                end
            end
            EXTERNAL: begin
                if (C7M_FALL && hold_reg != HOLD_W'(HOLD_LIMIT)) begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
                // Set dominates a coincident clear while the tenure sits at the limit
                if (hold_next == HOLD_W'(HOLD_LIMIT)) begin
                    ovf_next = 1'b1;
                end
                if (bgack_s) begin
                    state_next    = RELEASE;
                    from_ext_next = 1'b1;
                end
            end
            RELEASE: begin
                if (C7M_FALL && gap_reg != GAP_W'(REARB_GAP)) begin
                    gap_next = gap_reg + GAP_W'(1);
                end
                if (gap_reg == GAP_W'(REARB_GAP)) begin
                    state_next     = IDLE;
                    after_ext_next = from_ext_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            tmo_next       = '0;
            gap_next       = '0;
            hold_next      = '0;
            busy_seen_next = 1'b0;
            if (state_next == LOCAL || state_next == GRANT_PEND) begin
                after_ext_next = 1'b0;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= IDLE;
            tmo_reg       <= '0;
            gap_reg       <= '0;
            hold_reg      <= '0;
            after_ext_reg <= 1'b0;
            from_ext_reg  <= 1'b0;
            busy_seen_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            bg_n_reg      <= 1'b1;
            cyc_grant_reg <= 1'b0;
            bus_own_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            tmo_reg       <= tmo_next;
            gap_reg       <= gap_next;
            hold_reg      <= hold_next;
            after_ext_reg <= after_ext_next;
            from_ext_reg  <= from_ext_next;
            busy_seen_reg <= busy_seen_next;
            ovf_reg       <= ovf_next;
            bg_n_reg      <= (state_next != GRANT_PEND);
            cyc_grant_reg <= (state_next == LOCAL);
            bus_own_reg   <= !(state_next == EXTERNAL || state_next == RELEASE);
        end
    end

    assign M68K_BG_n    = bg_n_reg;
    assign CYC_GRANT    = cyc_grant_reg;
    assign BUS_OWN      = bus_own_reg;
    assign EXT_HOLD_OVF = ovf_reg;
    assign ARB_STATE    = state_reg;

endmodule
